alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_arbiter_alu.sv | 34 +++
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU arbiter slice.
//   - datapath and opcode widths
//   - ALUControl opcode constants
//   - ALUFlags bit indices ({eq, lt, ltu})
//   - arbiter FSM state enum
//   - helpers: opcode legality check and operand compare flags
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CTL_W  = 4;
  localparam int FLAG_W = 3;

  localparam logic [CTL_W-1:0] OP_ADD = 4'b0000;
  localparam logic [CTL_W-1:0] OP_SUB = 4'b0001;
  localparam logic [CTL_W-1:0] OP_AND = 4'b1110;
  localparam logic [CTL_W-1:0] OP_OR  = 4'b1100;
  localparam logic [CTL_W-1:0] OP_SLL = 4'b0010;
  localparam logic [CTL_W-1:0] OP_SRL = 4'b1010;
  localparam logic [CTL_W-1:0] OP_SRA = 4'b1011;

  localparam int FLAG_EQ  = 2;
  localparam int FLAG_LT  = 1;
  localparam int FLAG_LTU = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  function automatic logic op_legal(input logic [CTL_W-1:0] ctl);
    logic ok;
    ok = 1'b0;
    case (ctl)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_SRA: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Flags compare the operands, not the result, so they are meaningful
  // for every opcode.
  function automatic logic [FLAG_W-1:0] cmp_flags(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [FLAG_W-1:0] f;
    f           = '0;
    f[FLAG_EQ]  = (a == b);
    f[FLAG_LT]  = ($signed(a) < $signed(b));
    f[FLAG_LTU] = (a < b);
    return f;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational 32-bit ALU used as the shared datapath.
// Ports:
//   a, b         operands
//   alu_control  opcode (see alu_pkg OP_*)
//   result       operation result; unknown opcodes give 0
// Shift amount is b[4:0]; upper bits of b are ignored for shifts.
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [CTL_W-1:0]  alu_control,
  output logic [DATA_W-1:0] result
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (alu_control)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter in front of one shared ALU.
// One operation is outstanding at a time: accept (IDLE) -> execute (EXEC)
// -> hold response until consumed (RESP).
//
// Parameters:
//   PRIO_INIT   requester that wins the first simultaneous request after reset
// Build options:
//   ALU_ARB_FIXED_PRIO_EN  defined: requester 0 always wins simultaneous
//                          requests (PRIO_INIT ignored); undefined: round-robin
// Ports:
//   CLK, RESETn                    clock, async active-low reset
//   reqN_valid / reqN_ready        request handshake of requester N
//   Src_AN, Src_BN, ALUControlN    operands and opcode of requester N
//   rspN_valid / rspN_ready        response handshake of requester N
//   ALUResult, ALUFlags, rsp_err   shared response bus ({eq, lt, ltu} flags)
//
// state | meaning
// IDLE  | waiting for a request; ready asserted to the granted requester
// EXEC  | registered operands drive the ALU; result captured at end of cycle
// RESP  | rsp_valid of the granted requester held until its rsp_ready
module alu_arbiter
  import alu_pkg::*;
#(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] Src_A0,
  input  logic [DATA_W-1:0] Src_A1,
  input  logic [DATA_W-1:0] Src_B0,
  input  logic [DATA_W-1:0] Src_B1,
  input  logic [CTL_W-1:0]  ALUControl0,
  input  logic [CTL_W-1:0]  ALUControl1,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] ALUResult,
  output logic [FLAG_W-1:0] ALUFlags,
  output logic              rsp_err
);

  arb_state_e        state, state_nxt;
  logic              grant;
  logic              accept;
  logic              rsp_done;
  logic              grant_id;
  logic              last_grant;
  logic [DATA_W-1:0] op_a, op_b;
  logic [CTL_W-1:0]  op_ctl;
  logic [DATA_W-1:0] alu_y;

  // Grant selection; only meaningful while in IDLE.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept   = req0_ready | req1_ready;
  assign rsp_done = (state == RESP) && (grant_id ? rsp1_ready : rsp0_ready);

  // FSM: state register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. Returning to IDLE on the handshake cycle keeps the ready
  // outputs low in that cycle, so accepts are at least three cycles apart.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid &&  grant;
      end
      RESP: begin
        rsp0_valid = !grant_id;
        rsp1_valid =  grant_id;
      end
      default: ;
    endcase
  end

  // Capture the winning request.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      op_a       <= '0;
      op_b       <= '0;
      op_ctl     <= OP_ADD;
      grant_id   <= 1'b0;
      last_grant <= ~PRIO_INIT;
    end else if (accept) begin
      op_a       <= grant ? Src_A1 : Src_A0;
      op_b       <= grant ? Src_B1 : Src_B0;
      op_ctl     <= grant ? ALUControl1 : ALUControl0;
      grant_id   <= grant;
      last_grant <= grant;
    end
  end

  alu_arbiter_alu u_alu (
    .a           (op_a),
    .b           (op_b),
    .alu_control (op_ctl),
    .result      (alu_y)
  );

  // Response registers load only at the end of EXEC, so they stay stable
  // for the whole RESP phase regardless of how long rsp_ready is held off.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ALUResult <= '0;
      ALUFlags  <= '0;
      rsp_err   <= 1'b0;
    end else if (state == EXEC) begin
      if (op_legal(op_ctl)) begin
        ALUResult <= alu_y;
        ALUFlags  <= cmp_flags(op_a, op_b);
        rsp_err   <= 1'b0;
      end else begin
        ALUResult <= '0;
        ALUFlags  <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule
